// File: rtl/vga_line_sched.sv
// vga_line_sched: streams frame lines from a word-addressed memory into a two-bank
// line buffer and serves one RGB565 pixel per Data_Req from the display bank.
// One bank fills from memory while the other is shown; underruns replay the shown line.
module vga_line_sched #(
    parameter int unsigned H_PIX     = 800,
    parameter int unsigned V_LINES   = 480,
    parameter int unsigned BASE_ADDR = 0
) (
    input  logic        Clk,
    input  logic        Reset_n,
    input  logic        frame_start,
    input  logic        Data_Req,
    output logic [15:0] DATA,
    output logic        mem_req,
    output logic [20:0] mem_addr,
    input  logic        mem_ack,
    input  logic [15:0] mem_rdata,
    output logic        underrun,
    output logic [7:0]  underrun_cnt,
    output logic        busy
);

    localparam int unsigned PW = (H_PIX > 1) ? $clog2(H_PIX) : 1;
    // Line counters must be able to hold V_LINES itself (end-of-frame marker).
    localparam int unsigned LW = $clog2(V_LINES + 1);

    localparam logic [PW-1:0] LastPix  = PW'(H_PIX - 1);
    localparam logic [LW-1:0] NumLines = LW'(V_LINES);

    typedef enum logic [2:0] {
        StIdle,
        StPrefill,
        StFetch,
        StHold,
        StDone
    } state_e;

    state_e        state_q, state_d;
    logic [LW-1:0] fl_q, fl_d;          // line being fetched
    logic [LW-1:0] dl_q, dl_d;          // line being displayed
    logic [PW-1:0] wx_q, wx_d;          // fill word index
    logic [PW-1:0] px_q, px_d;          // display pixel index
    logic          fill_sel_q, fill_sel_d;
    logic          disp_sel_q, disp_sel_d;
    logic          mem_req_q, mem_req_d;
    logic [20:0]   mem_addr_q, mem_addr_d;
    logic [15:0]   data_q, data_d;
    logic          underrun_q, underrun_d;
    logic [7:0]    cnt_q, cnt_d;

    // Two banks of one line each; not reset.
    logic [15:0]   line_buf [2][H_PIX];

    logic wr_en;
    logic wr_last;
    logic disp_active;
    logic consume;
    logic line_end;
    logic abort;
    logic fetching_d;
    logic active_d;
    logic bypass;

    // Event decode: memory write, pixel consumption and end of display line.
    always_comb begin
        wr_en       = mem_req_q && mem_ack && !frame_start;
        wr_last     = wr_en && (wx_q == LastPix);
        disp_active = ((state_q == StFetch) || (state_q == StHold) || (state_q == StDone))
                      && (dl_q < NumLines);
        consume     = Data_Req && disp_active && !frame_start;
        line_end    = consume && (px_q == LastPix);
        abort       = frame_start && (state_q != StIdle);
    end

    // Next-state logic for the FSM, line/pixel counters and bank selects.
    always_comb begin
        state_d    = state_q;
        fl_d       = fl_q;
        dl_d       = dl_q;
        wx_d       = wx_q;
        px_d       = px_q;
        fill_sel_d = fill_sel_q;
        disp_sel_d = disp_sel_q;
        underrun_d = 1'b0;
        cnt_d      = cnt_q;

        if (frame_start) begin
            // Restart the frame from any state; the underrun count survives.
            state_d    = StPrefill;
            fl_d       = '0;
            dl_d       = '0;
            wx_d       = '0;
            fill_sel_d = 1'b0;
        end else begin
            if (wr_en) begin
                wx_d = wr_last ? '0 : wx_q + 1'b1;
            end

            unique case (state_q)
                StPrefill: begin
                    if (wr_last) begin
                        fill_sel_d = ~fill_sel_q;
                        disp_sel_d = fill_sel_q;
                        px_d       = '0;
                        fl_d       = fl_q + 1'b1;
                        state_d    = (V_LINES > 1) ? StFetch : StDone;
                    end
                end
                StFetch: begin
                    if (line_end) begin
                        // Next line not ready: replay the current display bank.
                        underrun_d = 1'b1;
                        if (cnt_q != 8'hFF) begin
                            cnt_d = cnt_q + 8'd1;
                        end
                        px_d = '0;
                    end else if (consume) begin
                        px_d = px_q + 1'b1;
                    end
                    if (wr_last) begin
                        state_d = StHold;
                    end
                end
                StHold: begin
                    if (line_end) begin
                        fill_sel_d = ~fill_sel_q;
                        disp_sel_d = fill_sel_q;
                        px_d       = '0;
                        dl_d       = dl_q + 1'b1;
                        fl_d       = fl_q + 1'b1;
                        state_d    = (fl_d < NumLines) ? StFetch : StDone;
                    end else if (consume) begin
                        px_d = px_q + 1'b1;
                    end
                end
                StDone: begin
                    // dl reaching V_LINES marks the frame as fully shown.
                    if (line_end) begin
                        dl_d = dl_q + 1'b1;
                        px_d = '0;
                    end else if (consume) begin
                        px_d = px_q + 1'b1;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    // Registered memory request/address and the prefetched pixel.
    always_comb begin
        fetching_d = (state_d == StPrefill) || (state_d == StFetch);
        // One idle request cycle after each completed line and after an abort.
        mem_req_d  = fetching_d && !wr_last && !abort;
        mem_addr_d = fetching_d ? 21'(BASE_ADDR + 32'(fl_d) * H_PIX + 32'(wx_d)) : mem_addr_q;

        active_d = ((state_d == StFetch) || (state_d == StHold) || (state_d == StDone))
                   && (dl_d < NumLines);
        // Forward the word being written if it is the one about to be shown.
        bypass   = wr_en && (fill_sel_q == disp_sel_d) && (wx_q == px_d);
        if (!active_d) begin
            data_d = '0;
        end else if (bypass) begin
            data_d = mem_rdata;
        end else begin
            data_d = line_buf[disp_sel_d][px_d];
        end
    end

    // State and output registers with synchronous active-low reset.
    always_ff @(posedge Clk) begin
        if (!Reset_n) begin
            state_q    <= StIdle;
            fl_q       <= '0;
            dl_q       <= '0;
            wx_q       <= '0;
            px_q       <= '0;
            fill_sel_q <= 1'b0;
            disp_sel_q <= 1'b0;
            mem_req_q  <= 1'b0;
            mem_addr_q <= '0;
            data_q     <= '0;
            underrun_q <= 1'b0;
            cnt_q      <= '0;
        end else begin
            state_q    <= state_d;
            fl_q       <= fl_d;
            dl_q       <= dl_d;
            wx_q       <= wx_d;
            px_q       <= px_d;
            fill_sel_q <= fill_sel_d;
            disp_sel_q <= disp_sel_d;
            mem_req_q  <= mem_req_d;
            mem_addr_q <= mem_addr_d;
            data_q     <= data_d;
            underrun_q <= underrun_d;
            cnt_q      <= cnt_d;
        end
    end

    // Line buffer write port; contents deliberately survive reset.
    always_ff @(posedge Clk) begin
        if (wr_en) begin
            line_buf[fill_sel_q][wx_q] <= mem_rdata;
        end
    end

    assign DATA         = data_q;
    assign mem_req      = mem_req_q;
    assign mem_addr     = mem_addr_q;
    assign underrun     = underrun_q;
    assign underrun_cnt = cnt_q;
    assign busy         = (state_q == StPrefill) || (state_q == StFetch) || (state_q == StHold);

endmodule

// File: doc/vga_line_sched.md
VGA_LINE_SCHED -- requirements
Module: vga_line_sched

Interface
REQ-001 The block SHALL have parameter H_PIX, default 800, meaning pixels per active line.
REQ-002 The block SHALL have parameter V_LINES, default 480, meaning active lines per frame.
REQ-003 The block SHALL have parameter BASE_ADDR, default 0, meaning the word address of pixel (0,0) in memory.
REQ-004 The block SHALL have port Clk, input, 1 bit: the single clock; all logic is clocked on its rising edge.
REQ-005 The block SHALL have port Reset_n, input, 1 bit: reset, synchronous and active-low.
REQ-006 The block SHALL have port frame_start, input, 1 bit: a one-cycle pulse at the start of each frame's vertical blank.
REQ-007 The block SHALL have port Data_Req, input, 1 bit: the display controller's pixel request; one pixel is consumed per high cycle.
REQ-008 The block SHALL have port DATA, output, 16 bits: the RGB565 pixel, valid in the same cycle Data_Req is high.
REQ-009 The block SHALL have port mem_req, output, 1 bit: the memory word read request.
REQ-010 The block SHALL have port mem_addr, output, 21 bits: the memory word address, held stable while mem_req is high.
REQ-011 The block SHALL have port mem_ack, input, 1 bit: accepts the current request; mem_rdata is valid in this cycle.
REQ-012 The block SHALL have port mem_rdata, input, 16 bits: the read data.
REQ-013 The block SHALL have port underrun, output, 1 bit: a one-cycle pulse when the display finishes a line before the next line is fully fetched.
REQ-014 The block SHALL have port underrun_cnt, output, 8 bits: a saturating count of underrun events.
REQ-015 The block SHALL have port busy, output, 1 bit: high whenever the FSM is not in IDLE or DONE.

Function
REQ-016 The block SHALL hold a two-bank line buffer, 2 x H_PIX x 16 bits; one bank is the fill bank and the other is the display bank.
REQ-017 The FSM SHALL have the states IDLE, PREFILL, FETCH, HOLD and DONE.
REQ-018 IDLE -> PREFILL on frame_start, with line index fl=0, fill bank=0 and display line dl=0.
REQ-019 In PREFILL and FETCH, mem_req SHALL be 1 and mem_addr SHALL be BASE_ADDR + fl*H_PIX + wx, where wx is the fill word index; the sum is truncated to 21 bits.
REQ-020 On each mem_ack, mem_rdata SHALL be written to fill bank[wx] and wx SHALL increment; mem_req SHALL drop in the cycle after the ack of word H_PIX-1.
REQ-021 When PREFILL completes (wx reaches H_PIX), the banks SHALL swap, the display pointer px SHALL be set to 0, fl SHALL increment, and the FSM SHALL go to FETCH if V_LINES>1, else to DONE.
REQ-022 When FETCH completes, the FSM SHALL go to HOLD.
REQ-023 The display line SHALL end on the Data_Req that consumes px=H_PIX-1.
REQ-024 At the end of a display line with the FSM in HOLD, the banks SHALL swap, px SHALL be set to 0, dl and fl SHALL increment, and the FSM SHALL go to FETCH if fl<V_LINES, else to DONE.
REQ-025 At the end of a display line with the FSM in FETCH, the block SHALL pulse underrun, increment underrun_cnt (saturating at 255), set px to 0 and replay the same display bank; the fetch SHALL continue unaffected.
REQ-026 At the end of the last display line (dl=V_LINES-1) in DONE, the FSM SHALL stay in DONE and further Data_Req SHALL return 0.
REQ-027 DATA SHALL be a registered prefetch holding display bank[px]; on Data_Req, px SHALL advance and DATA SHALL update to the next word one cycle later, with no bubbles under back-to-back Data_Req.
REQ-028 Data_Req while in IDLE or PREFILL SHALL be ignored: DATA=0, px unchanged, no underrun.
REQ-029 A frame_start in any state other than IDLE SHALL abort the current request (mem_req low for one cycle) and restart PREFILL with fl=0 and dl=0; underrun_cnt SHALL be kept.
REQ-030 When frame_start and mem_ack occur in the same cycle, frame_start SHALL win and the acked word SHALL be discarded.
REQ-031 The block SHALL have a latency of H_PIX acks from frame_start to the first valid DATA.

Reset
REQ-032 When Reset_n=0 at a clock edge, the FSM SHALL enter IDLE and the block SHALL clear DATA, mem_req, mem_addr, underrun, underrun_cnt, busy, fl, dl, px and wx, and set both bank selects to 0.
REQ-033 The line buffer contents SHALL NOT be reset.
REQ-034 A reset mid-fetch SHALL drop mem_req in the next cycle.

Verification
REQ-035 Test with H_PIX=4, V_LINES=3, BASE_ADDR=100 and mem_ack always 1: frame_start -> mem_addr 100,101,102,103, then FETCH 104..107; Data_Req x4 -> DATA = words from 100..103.
REQ-036 Test a slow memory (ack every 4th cycle) with continuous Data_Req: expect an underrun pulse, underrun_cnt=1 and line 0 replayed.
REQ-037 Test a full frame with V_LINES=3: after 12 Data_Req the FSM is in DONE, mem_req=0, and a 13th Data_Req returns DATA=0.
REQ-038 Test frame_start asserted at wx=2 of line 1: expect the next mem_addr = 100 and PREFILL restarted, with underrun_cnt unchanged.
REQ-039 Test Reset_n=0 for 1 cycle mid-FETCH: expect mem_req=0, busy=0, underrun_cnt=0 and DATA=0 on the next edge.
REQ-040 Test 300 forced underruns: expect underrun_cnt saturated at 255.
